// File: rtl/audio_pdm_out.sv
// rtl/audio_pdm_out.sv - voice sample to one-bit sigma-delta / PWM output (option: AUDIO_PDM_DITHER_EN)
module audio_pdm_out #(
  parameter int WAVE_BITS = 8,
  parameter int VOL_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WAVE_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic [VOL_BITS-1:0]  volume,
  input  logic                 mode,
  output logic                 audio_out
);

  localparam logic [WAVE_BITS-1:0] HALF    = {1'b1, {(WAVE_BITS-1){1'b0}}};
  localparam logic [WAVE_BITS-1:0] CNT_MAX = {WAVE_BITS{1'b1}};

  logic [WAVE_BITS-1:0] held_q, held_d;
  logic [WAVE_BITS-1:0] acc_q, acc_d;
  logic [WAVE_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [WAVE_BITS-1:0] duty_q, duty_d;
  logic                 mode_q, mode_d;
  logic                 out_q, out_d;

  logic signed [WAVE_BITS-1:0] scaled;
  logic [WAVE_BITS-1:0]        level;
  logic [WAVE_BITS:0]          sum;
  logic                        dither;

  // Arithmetic shift keeps the sign, so re-biasing by half scale can never overflow.
  assign scaled = $signed(held_q) >>> volume;
  assign level  = $unsigned(scaled) + HALF;
  assign sum    = {1'b0, acc_q} + {1'b0, level};

`ifdef AUDIO_PDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign dither  = lfsr_q[0];

  // Dither source: 16-bit Fibonacci LFSR stepping on every enabled edge.
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign dither = 1'b0;
`endif

  // Next-state logic: sample capture, mode switch, and one modulator step.
  always_comb begin
    held_d    = held_q;
    acc_d     = acc_q;
    pwm_cnt_d = pwm_cnt_q;
    duty_d    = duty_q;
    mode_d    = mode_q;
    out_d     = 1'b0;

    // Capture ignores enable; the latest strobe wins.
    if (sample_valid) begin
      held_d = sample_in;
    end

    if (enable) begin
      if (mode != mode_q) begin
        // Switch modes cleanly: new mode starts from zeroed counters next edge.
        mode_d    = mode;
        acc_d     = '0;
        pwm_cnt_d = '0;
        duty_d    = level;
        out_d     = 1'b0;
      end else if (!mode_q) begin
        // Sigma-delta: carry out of the accumulator is the output bit.
        out_d = sum[WAVE_BITS];
        acc_d = sum[WAVE_BITS-1:0] ^ {{(WAVE_BITS-1){1'b0}}, dither};
      end else begin
        // PWM: duty only reloads at the period boundary so periods never glitch.
        out_d     = (pwm_cnt_q < duty_q);
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        if (pwm_cnt_q == CNT_MAX) begin
          duty_d = level;
        end
      end
    end
  end

  // State registers; reset overrides any pending sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q    <= '0;
      acc_q     <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= HALF;
      mode_q    <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      held_q    <= held_d;
      acc_q     <= acc_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      mode_q    <= mode_d;
      out_q     <= out_d;
    end
  end

  assign audio_out = out_q;

endmodule

// File: tb/tb_audio_pdm_out.sv
// tb/tb_audio_pdm_out.sv - self-checking bench for audio_pdm_out
module tb_audio_pdm_out;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [2:0] volume;
  logic       mode;
  logic       audio_out;

  int errors = 0;
  int checks = 0;
  int ones   = 0;

  // Reference state, kept as plain integers
  int m_held, m_acc, m_cnt, m_duty, m_modeq, m_out;

  always #5 clk = ~clk;

  audio_pdm_out #(.WAVE_BITS(8), .VOL_BITS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .volume       (volume),
    .mode         (mode),
    .audio_out    (audio_out)
  );

  function automatic int level(int h, int v);
    return (h >>> v) + 128;
  endfunction

  task automatic model_edge();
    int u;
    u = level(m_held, int'(volume));
    if (reset) begin
      m_held = 0; m_acc = 0; m_cnt = 0; m_duty = 128; m_modeq = 0; m_out = 0;
    end else begin
      if (!enable) begin
        m_out = 0;
      end else if (int'(mode) != m_modeq) begin
        m_modeq = int'(mode); m_acc = 0; m_cnt = 0; m_duty = u; m_out = 0;
      end else if (m_modeq == 0) begin
        m_out = (m_acc + u) / 256;
        m_acc = (m_acc + u) % 256;
      end else begin
        m_out = (m_cnt < m_duty) ? 1 : 0;
        if (m_cnt == 255) m_duty = u;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (sample_valid) m_held = int'($signed(sample_in));
    end
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (audio_out === 1'b1) ones++;
    chk("model_out", audio_out, m_out[0]);
  endtask

  task automatic strobe(logic [7:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic window(string tag, int n, int exp);
    ones = 0;
    for (int i = 0; i < n; i++) step();
    chk_int(tag, ones, exp);
  endtask

  initial begin
    int v, vol;
    reset = 1'b1; enable = 1'b1; mode = 1'b0; sample_valid = 1'b0;
    sample_in = 8'h00; volume = 3'd0;

    // 1: reset state then strict alternation from u=128
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_out", audio_out, 1'b0);
    end
    reset = 1'b0;
    step();
    chk("first_enabled", audio_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("alternate", audio_out, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // 2: full-scale samples
    strobe(8'h7F);
    window("sd_7f_255", 256, 255);
    strobe(8'h80);
    window("sd_80_0", 256, 0);

    // 3: maximum attenuation
    volume = 3'd7;
    strobe(8'h7F);
    window("vol7_7f_128", 256, 128);
    strobe(8'h80);
    window("vol7_80_127", 256, 127);

    // 4: PWM, sample strobed mid-period keeps current duty
    volume = 3'd0;
    strobe(8'h00);
    mode = 1'b1;
    step();
    chk("mode_switch_out", audio_out, 1'b0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) strobe(8'h40);
      else step();
    end
    chk_int("pwm_old_period", ones, 128);
    window("pwm_new_period", 256, 192);

    // 5: enable gap mid-period
    ones = 0;
    for (int i = 0; i < 50; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_out", audio_out, 1'b0);
    end
    enable = 1'b1;
    for (int i = 0; i < 206; i++) step();
    chk_int("pwm_gap_period", ones, 192);

    // 6: toggle 0->1 mid-stream, then reset with a discarded strobe
    mode = 1'b0;
    for (int i = 0; i < 21; i++) step();
    mode = 1'b1;
    step();
    chk("toggle_out", audio_out, 1'b0);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1; mode = 1'b0;
    sample_in = 8'h7F; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_reset_first", audio_out, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_reset_alt", audio_out, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Random constant-level windows in sigma-delta mode
    for (int k = 0; k < 4; k++) begin
      v = int'($urandom_range(0, 255));
      vol = int'($urandom_range(0, 7));
      volume = 3'(vol);
      strobe(8'(v));
      window("sd_rand_window", 256, level(int'($signed(8'(v))), vol));
    end

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      sample_valid = ($urandom_range(0, 15) == 0);
      sample_in    = 8'($urandom);
      if ($urandom_range(0, 63) == 0) volume = 3'($urandom);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 399) == 0) mode = ~mode;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0; sample_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
